// File: rtl/md_unit_ctrl_if.sv
// Handshake and data bundle between the E-stage/decode logic and the MD unit.
// The master drives operands and control. The slave returns HI/LO, busy and stall_D.
interface md_unit_ctrl_if;
   logic        start;
   logic [2:0]  md_op;
   logic [31:0] A;
   logic [31:0] B;
   logic        md_in_D;
   logic [31:0] hi;
   logic [31:0] lo;
   logic        busy;
   logic        stall_D;

   modport master (
      output start, md_op, A, B, md_in_D,
      input  hi, lo, busy, stall_D
   );

   modport slave (
      input  start, md_op, A, B, md_in_D,
      output hi, lo, busy, stall_D
   );
endinterface

// File: rtl/md_unit_ctrl.sv
// Multi-cycle multiply/divide unit with HI/LO registers.
// Its sequencer holds the decode stage while an operation is in flight.
module md_unit_ctrl #(
   parameter int MULT_CYCLES = 5,
   parameter int DIV_CYCLES  = 10
) (
   input logic          clk,
   input logic          reset,
   md_unit_ctrl_if.slave bus
);
   localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
   localparam int CW   = $clog2(MAXC + 1);

   typedef enum logic {IDLE, RUN} state_t;

   state_t      state, state_n;
   logic [CW-1:0] cnt, cnt_n;
   logic [1:0]  op_q, op_n;
   logic [31:0] a_q, a_n, b_q, b_n;
   logic [31:0] hi_q, hi_n, lo_q, lo_n;

   logic signed [63:0] sa, sb, prod_s;
   logic [63:0]        prod_u;
   logic [31:0]        dvs, quo_s, rem_s, quo_u, rem_u;
   logic               ovf;

   always_comb begin
      sa     = {{32{a_q[31]}}, a_q};
      sb     = {{32{b_q[31]}}, b_q};
      prod_s = sa * sb;
      prod_u = {32'b0, a_q} * {32'b0, b_q};
      // divisor forced non-zero so the unused quotient never goes X; the result is discarded on B==0
      dvs    = (b_q == '0) ? 32'd1 : b_q;
      ovf    = (a_q == 32'h8000_0000) && (b_q == 32'hFFFF_FFFF);
      quo_s  = ovf ? 32'h8000_0000 : 32'($signed(a_q) / $signed(dvs));
      rem_s  = ovf ? 32'h0 : 32'($signed(a_q) % $signed(dvs));
      quo_u  = a_q / dvs;
      rem_u  = a_q % dvs;
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state <= IDLE;
         cnt   <= '0;
         op_q  <= '0;
         a_q   <= '0;
         b_q   <= '0;
         hi_q  <= '0;
         lo_q  <= '0;
      end else begin
         state <= state_n;
         cnt   <= cnt_n;
         op_q  <= op_n;
         a_q   <= a_n;
         b_q   <= b_n;
         hi_q  <= hi_n;
         lo_q  <= lo_n;
      end
   end

   always_comb begin
      state_n = state;
      cnt_n   = cnt;
      op_n    = op_q;
      a_n     = a_q;
      b_n     = b_q;
      hi_n    = hi_q;
      lo_n    = lo_q;
      case (state)
         IDLE: begin
            if (bus.start) begin
               case (bus.md_op)
                  3'd0, 3'd1, 3'd2, 3'd3: begin
                     op_n    = bus.md_op[1:0];
                     a_n     = bus.A;
                     b_n     = bus.B;
                     cnt_n   = bus.md_op[1] ? CW'(DIV_CYCLES) : CW'(MULT_CYCLES);
                     state_n = RUN;
                  end
                  3'd4:    hi_n = bus.A;
                  3'd5:    lo_n = bus.A;
                  default: ;
               endcase
            end
         end
         RUN: begin
            if (cnt == CW'(1)) begin
               cnt_n   = '0;
               state_n = IDLE;
               case (op_q)
                  2'd0: {hi_n, lo_n} = prod_s;
                  2'd1: {hi_n, lo_n} = prod_u;
                  2'd2: if (b_q != '0) begin
                     hi_n = rem_s;
                     lo_n = quo_s;
                  end
                  default: if (b_q != '0) begin
                     hi_n = rem_u;
                     lo_n = quo_u;
                  end
               endcase
            end else begin
               cnt_n = cnt - CW'(1);
            end
         end
         default: state_n = IDLE;
      endcase
   end

   assign bus.hi      = hi_q;
   assign bus.lo      = lo_q;
   assign bus.busy    = (state == RUN);
   assign bus.stall_D = bus.md_in_D & ((state == RUN) | (bus.start & ~bus.md_op[2]));
endmodule

// File: tb/tb_md_unit_ctrl.sv
// Directed self-checking bench for md_unit_ctrl.
// Expected values are computed by hand from the reference behaviour.
module tb_md_unit_ctrl;
   logic clk = 1'b0;
   logic reset = 1'b0;
   int   passed = 0;
   int   total = 0;

   md_unit_ctrl_if bus ();

   md_unit_ctrl #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Issue one operation and count the cycles with busy high (bounded).
   task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         output int cycles);
      bus.start = 1'b1;
      bus.md_op = op;
      bus.A     = a;
      bus.B     = b;
      tick();
      bus.start = 1'b0;
      bus.A     = 32'hDEAD_BEEF;
      bus.B     = 32'h0BAD_F00D;
      cycles    = 0;
      while (bus.busy && cycles < 100) begin
         cycles++;
         tick();
      end
   endtask

   task automatic test_reset();
      int n;
      bus.start = 1'b0; bus.md_op = 3'd7; bus.A = '0; bus.B = '0; bus.md_in_D = 1'b0;
      reset = 1'b0;
      tick(); tick();
      total++; if (bus.hi !== 32'h0) $display("FAIL reset_hi got %h want %h", bus.hi, 32'h0); else passed++;
      total++; if (bus.lo !== 32'h0) $display("FAIL reset_lo got %h want %h", bus.lo, 32'h0); else passed++;
      total++; if (bus.busy !== 1'b0) $display("FAIL reset_busy got %b want 0", bus.busy); else passed++;
      reset = 1'b1;
      bus.start = 1'b1; bus.md_op = 3'd3; bus.A = 32'd7; bus.B = 32'd2;
      tick();
      bus.start = 1'b0;
      tick(); tick();
      reset = 1'b0;
      tick(); tick();
      total++; if (bus.busy !== 1'b0) $display("FAIL reset_run_busy got %b want 0", bus.busy); else passed++;
      reset = 1'b1;
      n = 0;
      while (n < 15) begin
         n++;
         tick();
      end
      total++; if (bus.hi !== 32'h0) $display("FAIL reset_late_hi got %h want %h", bus.hi, 32'h0); else passed++;
      total++; if (bus.lo !== 32'h0) $display("FAIL reset_late_lo got %h want %h", bus.lo, 32'h0); else passed++;
      total++; if (bus.busy !== 1'b0) $display("FAIL reset_late_busy got %b want 0", bus.busy); else passed++;
   endtask

   task automatic test_mult();
      int n;
      run_op(3'd0, 32'hFFFF_FFFE, 32'd3, n);
      total++; if (n !== 5) $display("FAIL mult_cycles got %0d want 5", n); else passed++;
      total++; if (bus.hi !== 32'hFFFF_FFFF) $display("FAIL mult_hi got %h want ffffffff", bus.hi); else passed++;
      total++; if (bus.lo !== 32'hFFFF_FFFA) $display("FAIL mult_lo got %h want fffffffa", bus.lo); else passed++;
      run_op(3'd1, 32'hFFFF_FFFE, 32'd3, n);
      total++; if (n !== 5) $display("FAIL multu_cycles got %0d want 5", n); else passed++;
      total++; if (bus.hi !== 32'h0000_0002) $display("FAIL multu_hi got %h want 00000002", bus.hi); else passed++;
      total++; if (bus.lo !== 32'hFFFF_FFFA) $display("FAIL multu_lo got %h want fffffffa", bus.lo); else passed++;
   endtask

   task automatic test_div();
      int n;
      run_op(3'd2, 32'hFFFF_FFF9, 32'd2, n);
      total++; if (n !== 10) $display("FAIL div_cycles got %0d want 10", n); else passed++;
      total++; if (bus.lo !== 32'hFFFF_FFFD) $display("FAIL div_lo got %h want fffffffd", bus.lo); else passed++;
      total++; if (bus.hi !== 32'hFFFF_FFFF) $display("FAIL div_hi got %h want ffffffff", bus.hi); else passed++;
      run_op(3'd3, 32'd7, 32'd2, n);
      total++; if (n !== 10) $display("FAIL divu_cycles got %0d want 10", n); else passed++;
      total++; if (bus.lo !== 32'd3) $display("FAIL divu_lo got %h want 00000003", bus.lo); else passed++;
      total++; if (bus.hi !== 32'd1) $display("FAIL divu_hi got %h want 00000001", bus.hi); else passed++;
      run_op(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, n);
      total++; if (bus.lo !== 32'h8000_0000) $display("FAIL div_ovf_lo got %h want 80000000", bus.lo); else passed++;
      total++; if (bus.hi !== 32'h0) $display("FAIL div_ovf_hi got %h want 00000000", bus.hi); else passed++;
   endtask

   task automatic test_div_zero();
      int n;
      bus.start = 1'b1; bus.md_op = 3'd4; bus.A = 32'h11;
      tick();
      total++; if (bus.busy !== 1'b0) $display("FAIL mthi_busy got %b want 0", bus.busy); else passed++;
      total++; if (bus.hi !== 32'h11) $display("FAIL mthi_hi got %h want 00000011", bus.hi); else passed++;
      bus.md_op = 3'd5; bus.A = 32'h22;
      tick();
      bus.start = 1'b0;
      total++; if (bus.lo !== 32'h22) $display("FAIL mtlo_lo got %h want 00000022", bus.lo); else passed++;
      total++; if (bus.hi !== 32'h11) $display("FAIL mtlo_hi_kept got %h want 00000011", bus.hi); else passed++;
      run_op(3'd2, 32'd100, 32'd0, n);
      total++; if (n !== 10) $display("FAIL div0_cycles got %0d want 10", n); else passed++;
      total++; if (bus.hi !== 32'h11) $display("FAIL div0_hi got %h want 00000011", bus.hi); else passed++;
      total++; if (bus.lo !== 32'h22) $display("FAIL div0_lo got %h want 00000022", bus.lo); else passed++;
      bus.start = 1'b1; bus.md_op = 3'd6; bus.A = 32'h99;
      tick();
      bus.start = 1'b0;
      total++; if (bus.busy !== 1'b0) $display("FAIL nop_busy got %b want 0", bus.busy); else passed++;
      total++; if (bus.hi !== 32'h11 || bus.lo !== 32'h22)
         $display("FAIL nop_hilo got %h/%h want 00000011/00000022", bus.hi, bus.lo); else passed++;
   endtask

   task automatic test_stall();
      int n;
      bus.md_in_D = 1'b1;
      bus.start = 1'b1; bus.md_op = 3'd0; bus.A = 32'd2; bus.B = 32'd3;
      #1;
      total++; if (bus.stall_D !== 1'b1) $display("FAIL stall_start got %b want 1", bus.stall_D); else passed++;
      tick();
      bus.start = 1'b0;
      n = 0;
      while (bus.busy && n < 100) begin
         n++;
         total++; if (bus.stall_D !== 1'b1) $display("FAIL stall_busy_c%0d got %b want 1", n, bus.stall_D); else passed++;
         tick();
      end
      total++; if (n !== 5) $display("FAIL stall_cycles got %0d want 5", n); else passed++;
      total++; if (bus.stall_D !== 1'b0) $display("FAIL stall_after got %b want 0", bus.stall_D); else passed++;
      total++; if (bus.lo !== 32'd6) $display("FAIL stall_lo got %h want 00000006", bus.lo); else passed++;
      bus.md_in_D = 1'b0;
      bus.start = 1'b1; bus.md_op = 3'd0;
      #1;
      total++; if (bus.stall_D !== 1'b0) $display("FAIL nostall_start got %b want 0", bus.stall_D); else passed++;
      tick();
      bus.start = 1'b0;
      total++; if (bus.busy !== 1'b1 || bus.stall_D !== 1'b0)
         $display("FAIL nostall_busy got busy=%b stall=%b want 1/0", bus.busy, bus.stall_D); else passed++;
      n = 0;
      while (bus.busy && n < 100) begin
         n++;
         tick();
      end
      bus.md_in_D = 1'b1;
      bus.start = 1'b1; bus.md_op = 3'd4; bus.A = 32'h55;
      #1;
      total++; if (bus.stall_D !== 1'b0) $display("FAIL mthi_stall got %b want 0", bus.stall_D); else passed++;
      tick();
      bus.start = 1'b0; bus.md_in_D = 1'b0;
   endtask

   task automatic test_back_to_back();
      int n;
      bus.start = 1'b1; bus.md_op = 3'd0; bus.A = 32'd3; bus.B = 32'd4;
      tick();
      bus.start = 1'b0;
      n = 1;
      tick();
      n++;
      bus.start = 1'b1; bus.md_op = 3'd0; bus.A = 32'd5; bus.B = 32'd5;
      tick();
      bus.start = 1'b0;
      if (bus.busy) n++;
      while (bus.busy && n < 100) begin
         tick();
         if (bus.busy) n++;
      end
      total++; if (n !== 5) $display("FAIL b2b_cycles got %0d want 5", n); else passed++;
      total++; if (bus.lo !== 32'd12) $display("FAIL b2b_lo got %h want 0000000c", bus.lo); else passed++;
      total++; if (bus.hi !== 32'd0) $display("FAIL b2b_hi got %h want 00000000", bus.hi); else passed++;
      tick(); tick();
      total++; if (bus.busy !== 1'b0) $display("FAIL b2b_no_restart got %b want 0", bus.busy); else passed++;
   endtask

   initial begin
      test_reset();
      test_mult();
      test_div();
      test_div_zero();
      test_stall();
      test_back_to_back();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
